// File: rtl/acc_seq_ctrl.sv
// Sequencing controller for the neuron multiply-accumulate datapath.
// Walks N_IN products per neuron and N_NEURON neurons per layer pass.
module acc_seq_ctrl #(
  parameter int N_IN     = 4,
  parameter int N_NEURON = 10,
  parameter int IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int NRN_W    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             in_valid,
  input  logic             abort,
  output logic             sel,
  output logic             acc_en,
  output logic             en,
  output logic [IDX_W-1:0] in_idx,
  output logic [NRN_W-1:0] neuron_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(N_IN - 1);
  localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(N_NEURON - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] in_idx_q, in_idx_d;
  logic [NRN_W-1:0] nrn_q, nrn_d;

  always_comb begin
    state_d  = state_q;
    in_idx_d = in_idx_q;
    nrn_d    = nrn_q;
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      in_idx_d = '0;
      nrn_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d  = S_LOAD;
            in_idx_d = '0;
            nrn_d    = '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (N_IN == 1) begin
              state_d = S_WRITE;
            end else begin
              state_d  = S_ACC;
              in_idx_d = IDX_W'(1);
            end
          end
        end
        S_ACC: begin
          if (in_valid) begin
            if (in_idx_q == IN_LAST) begin
              state_d = S_WRITE;
            end else begin
              in_idx_d = in_idx_q + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (nrn_q == NRN_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_LOAD;
            in_idx_d = '0;
            nrn_d    = nrn_q + NRN_W'(1);
          end
        end
        S_DONE: begin
          in_idx_d = '0;
          nrn_d    = '0;
          state_d  = cont ? S_LOAD : S_IDLE;
        end
        default: begin
          state_d  = S_IDLE;
          in_idx_d = '0;
          nrn_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      in_idx_q <= '0;
      nrn_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_idx_q <= in_idx_d;
      nrn_q    <= nrn_d;
    end
  end

  // sel/acc_en follow in_valid so a stalled product is never consumed
  assign sel        = (state_q == S_LOAD) && in_valid;
  assign acc_en     = (state_q == S_ACC) && in_valid;
  assign en         = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign in_idx     = in_idx_q;
  assign neuron_idx = nrn_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: two configurations checked against a
// slot-queue schedule model under directed and random stimulus.
module tb_acc_seq_ctrl;

  localparam int K_NONE = 0;
  localparam int K_LD   = 1;
  localparam int K_AC   = 2;
  localparam int K_WR   = 3;
  localparam int K_DN   = 4;

  typedef struct {
    int kind;
    int ii;
    int nn;
  } slot_t;

  logic clk = 1'b0;
  logic reset, start, cont, in_valid, abort;

  logic       sel_w[2], ae_w[2], en_w[2], busy_w[2], done_w[2];
  logic [1:0] ii0, nn0;
  logic [0:0] ii1, nn1;

  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    obs_done[2];
  slot_t q0[$];
  slot_t q1[$];

  always #5 clk = ~clk;

  acc_seq_ctrl #(.N_IN(4), .N_NEURON(3)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .cont(cont),
    .in_valid(in_valid), .abort(abort),
    .sel(sel_w[0]), .acc_en(ae_w[0]), .en(en_w[0]),
    .in_idx(ii0), .neuron_idx(nn0),
    .busy(busy_w[0]), .done(done_w[0])
  );

  acc_seq_ctrl #(.N_IN(1), .N_NEURON(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .cont(cont),
    .in_valid(in_valid), .abort(abort),
    .sel(sel_w[1]), .acc_en(ae_w[1]), .en(en_w[1]),
    .in_idx(ii1), .neuron_idx(nn1),
    .busy(busy_w[1]), .done(done_w[1])
  );

  function automatic int nin(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int nnr(int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic void qpush(int k, slot_t s);
    if (k == 0) q0.push_back(s);
    else q1.push_back(s);
  endfunction

  function automatic void qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endfunction

  function automatic void qclr(int k);
    if (k == 0) q0.delete();
    else q1.delete();
  endfunction

  function automatic bit qempty(int k);
    return (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
  endfunction

  function automatic slot_t qfront(int k);
    slot_t s;
    s = '{K_NONE, 0, 0};
    if (k == 0 && q0.size() > 0) s = q0[0];
    if (k == 1 && q1.size() > 0) s = q1[0];
    return s;
  endfunction

  // A pass is a list of slots: N_IN products + a write per neuron, then done
  function automatic void build(int k);
    for (int n = 0; n < nnr(k); n++) begin
      for (int i = 0; i < nin(k); i++)
        qpush(k, '{(i == 0) ? K_LD : K_AC, i, n});
      qpush(k, '{K_WR, nin(k) - 1, n});
    end
    qpush(k, '{K_DN, nin(k) - 1, nnr(k) - 1});
  endfunction

  function automatic void adv(int k);
    slot_t f;
    if (!reset) begin
      qclr(k);
      return;
    end
    if (qempty(k)) begin
      if (start && !abort) build(k);
      return;
    end
    if (abort) begin
      qclr(k);
      return;
    end
    f = qfront(k);
    if (f.kind == K_LD || f.kind == K_AC) begin
      if (in_valid) qpop(k);
    end else if (f.kind == K_WR) begin
      qpop(k);
    end else begin
      qpop(k);
      if (cont) build(k);
    end
  endfunction

  task automatic check(string tag, logic [31:0] got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic cmp_all();
    slot_t f;
    logic [31:0] gi, gn;
    for (int k = 0; k < 2; k++) begin
      f  = qfront(k);
      gi = (k == 0) ? 32'(ii0) : 32'(ii1);
      gn = (k == 0) ? 32'(nn0) : 32'(nn1);
      check($sformatf("d%0d.sel", k), 32'(sel_w[k]),
            int'(f.kind == K_LD && in_valid));
      check($sformatf("d%0d.acc_en", k), 32'(ae_w[k]),
            int'(f.kind == K_AC && in_valid));
      check($sformatf("d%0d.en", k), 32'(en_w[k]), int'(f.kind == K_WR));
      check($sformatf("d%0d.done", k), 32'(done_w[k]), int'(f.kind == K_DN));
      check($sformatf("d%0d.busy", k), 32'(busy_w[k]), int'(!qempty(k)));
      check($sformatf("d%0d.in_idx", k), gi, f.ii);
      check($sformatf("d%0d.neuron_idx", k), gn, f.nn);
      obs_done[k] = done_w[k];
    end
  endtask

  // Called at a negedge with inputs already set; returns at next negedge
  task automatic tick();
    #1;
    cmp_all();
    adv(0);
    adv(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    qclr(0);
    qclr(1);
    cmp_all();
    #2;
    reset = 1'b1;
  endtask

  task automatic run_pass(int ls, int ll, int e0, int e1, bit sb);
    int t0, t1;
    t0 = -1;
    t1 = -1;
    cont = 0;
    abort = 0;
    in_valid = 1;
    start = 1;
    tick();
    start = 0;
    for (int c = 1; c < 40; c++) begin
      in_valid = !(c >= ls && c < ls + ll);
      start = sb && (c == 3);
      tick();
      if (obs_done[0] && t0 < 0) t0 = c;
      if (obs_done[1] && t1 < 0) t1 = c;
    end
    start = 0;
    in_valid = 1;
    check("lat_done0", t0, e0);
    check("lat_done1", t1, e1);
  endtask

  initial begin
    reset = 0;
    start = 0;
    cont = 0;
    in_valid = 1;
    abort = 0;
    @(negedge clk);
    tick();
    tick();
    reset = 1;
    tick();

    run_pass(0, 0, 16, 5, 0);
    run_pass(3, 2, 18, 7, 0);
    run_pass(0, 0, 16, 5, 1);

    cont = 1;
    start = 1;
    tick();
    start = 0;
    for (int c = 1; c < 60; c++) begin
      if (c == 20) cont = 0;
      tick();
    end

    start = 1;
    tick();
    start = 0;
    for (int c = 1; c < 25; c++) begin
      abort = (c == 10);
      tick();
    end
    abort = 0;
    run_pass(0, 0, 16, 5, 0);

    start = 1;
    tick();
    start = 0;
    for (int c = 1; c < 4; c++) tick();
    pulse_reset();
    for (int c = 0; c < 5; c++) tick();

    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    tick();

    for (int c = 0; c < 1500; c++) begin
      start    = ($urandom_range(0, 7) == 0);
      cont     = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      abort    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) pulse_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Parametrised sequencing controller for the neuron multiply-accumulate datapath in the digit-recognition ANN.
- Steps the accumulator through N_IN products per neuron and through N_NEURON neurons per layer.
- Outputs: accumulator load-select (sel), accumulate enable, result-capture enable (en), input/neuron indices for weight and activation addressing, and a start/done handshake to the layer sequencer.
- Generalises the fixed 4-phase accumulator controller with configurable depth, neuron count, valid-gated stalling, abort, and continuous mode.

Parameters:
- N_IN, 4, products accumulated per neuron (>=1)
- N_NEURON, 10, neurons per layer pass (>=1)
- IDX_W, $clog2(N_IN) with minimum 1, in_idx width
- NRN_W, $clog2(N_NEURON) with minimum 1, neuron_idx width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a layer pass; sampled only in IDLE
- cont  in  1  continuous mode: on completion, restart the pass without a new start
- in_valid  in  1  current product valid; low stalls the sequence
- abort  in  1  synchronous abort to IDLE
- sel  out  1  load accumulator with first product (clears the old sum)
- acc_en  out  1  add current product to the accumulator
- en  out  1  capture the accumulator into the neuron output register
- in_idx  out  IDX_W  index of the current product
- neuron_idx  out  NRN_W  index of the current neuron
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of layer pass

Behaviour:
- States:
  - IDLE, LOAD, ACC, WRITE, DONE.
  - Registered state, in_idx and neuron_idx.
  - Outputs decoded from the registered state; sel and acc_en are additionally qualified by in_valid.
- Reset (reset=0, asynchronous):
  - state=IDLE, in_idx=0, neuron_idx=0.
  - sel=acc_en=en=done=busy=0.
  - Reset mid-pass discards the pass; no en or done is produced.
- IDLE: start=1 -> LOAD, with in_idx=0 and neuron_idx=0. Otherwise remain in IDLE.
- LOAD:
  - sel=in_valid.
  - in_valid=0: hold; counters frozen.
  - in_valid=1 and N_IN=1: -> WRITE.
  - in_valid=1 and N_IN>1: -> ACC, with in_idx=1.
- ACC:
  - acc_en=in_valid.
  - in_valid=0: hold.
  - in_valid=1 and in_idx<N_IN-1: increment in_idx.
  - in_valid=1 and in_idx=N_IN-1: -> WRITE.
- WRITE:
  - en=1 for exactly one cycle; not gated by in_valid.
  - neuron_idx<N_NEURON-1: neuron_idx++, in_idx=0, -> LOAD.
  - Otherwise -> DONE.
- DONE:
  - done=1 for one cycle.
  - cont=1: -> LOAD with both counters 0 (start not required).
  - cont=0: -> IDLE with both counters 0.
- Latency: with in_valid held high, each neuron takes N_IN+1 cycles. The first sel is asserted in the cycle after start is sampled. done is asserted N_NEURON*(N_IN+1)+1 cycles after start is sampled.
- abort=1 in any non-IDLE state: -> IDLE next edge; counters cleared; no en/done in the following cycle. abort has priority over every other transition, including the WRITE and DONE exits.
- start is ignored outside IDLE. start and abort together in IDLE: remain in IDLE.
- Counters never exceed N_IN-1 or N_NEURON-1. Index wrap to 0 occurs only via the WRITE and DONE transitions.
- sel, acc_en and en are mutually exclusive in every cycle.

Test Plan:
- N_IN=4, N_NEURON=3, in_valid=1, cont=0; pulse start at edge 0:
  - cycle 1: sel=1, in_idx=0.
  - cycles 2-4: acc_en=1, in_idx=1..3.
  - cycle 5: en=1, neuron_idx=0.
  - en repeats at cycles 10 and 15 (neuron_idx 1, 2).
  - cycle 16: done=1; cycle 17: IDLE, busy=0.
- Stall: same config, drop in_valid for 2 cycles while in ACC at in_idx=2 -> acc_en=0 and in_idx held at 2 for those cycles; the en for that neuron and done are both delayed by exactly 2 cycles.
- N_IN=1, N_NEURON=2, in_valid=1:
  - start -> sel at cycle 1, en at cycle 2, sel at cycle 3, en at cycle 4, done at cycle 5.
  - acc_en is never asserted.
- cont=1, N_IN=4, N_NEURON=3: after done at cycle 16, sel=1 at cycle 17 with neuron_idx=0 and no start. Deassert cont -> the pass that is running completes, then the block returns to IDLE.
- Abort during WRITE of neuron 1 -> en is high only in that cycle; next cycle IDLE, counters 0, no done. A subsequent start restarts from neuron_idx=0.
- Assert reset during ACC for half a cycle (asynchronous) -> outputs 0 immediately, state IDLE. start while busy (cycle 3) has no effect on the timing.
